// File: rtl/priority_encoder_generic_if.sv
// Request/result bundle for priority_encoder_generic.
// The onehot signal exists only when PRIO_ENC_ONEHOT_EN is defined.
`timescale 1ns/1ps
interface priority_encoder_generic_if #(
  parameter int n = 8
);
  localparam int YW = $clog2(n);

  logic [n-1:0]  w;
  logic          z;
  logic [YW-1:0] y;
`ifdef PRIO_ENC_ONEHOT_EN
  logic [n-1:0]  onehot;
`endif

`ifdef PRIO_ENC_ONEHOT_EN
  modport master (output w, input z, input y, input onehot);
  modport slave  (input w, output z, output y, output onehot);
`else
  modport master (output w, input z, input y);
  modport slave  (input w, output z, output y);
`endif
endinterface

// File: rtl/priority_encoder_generic.sv
// n-input priority encoder, highest index wins, registered z/y outputs.
// Optional registered one-hot output enabled by PRIO_ENC_ONEHOT_EN.
`timescale 1ns/1ps
module priority_encoder_generic #(
  parameter int n = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  priority_encoder_generic_if.slave   bus
);
  localparam int YW = $clog2(n);

  logic          z_next;
  logic [YW-1:0] y_next;
  logic          z_reg;
  logic [YW-1:0] y_reg;

  // Upward scan: the last set bit seen is the highest, so it wins.
  always_comb begin
    z_next = 1'b0;
    y_next = '0;
    for (int k = 0; k < n; k++) begin
      if (bus.w[k]) begin
        z_next = 1'b1;
        y_next = YW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z_reg <= 1'b0;
      y_reg <= '0;
    end else begin
      z_reg <= z_next;
      y_reg <= y_next;
    end
  end

  assign bus.z = z_reg;
  assign bus.y = y_reg;

`ifdef PRIO_ENC_ONEHOT_EN
  logic [n-1:0] onehot_next;
  logic [n-1:0] onehot_reg;

  // Decoding the winning index keeps onehot consistent with y by construction.
  for (genvar gi = 0; gi < n; gi++) begin : g_onehot
    assign onehot_next[gi] = z_next && (y_next == YW'(gi));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      onehot_reg <= '0;
    end else begin
      onehot_reg <= onehot_next;
    end
  end

  assign bus.onehot = onehot_reg;
`endif
endmodule

// File: tb/tb_priority_encoder_generic.sv
// Self-checking bench: three encoders (n=6, 2, 64) driven in lock-step,
// compared against a floor(log2) reference model and a vector table.
`timescale 1ns/1ps
module tb_priority_encoder_generic;
  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  logic [5:0]  p6;
  logic [1:0]  p2;
  logic [63:0] p64;

  priority_encoder_generic_if #(.n(6))  bus6 ();
  priority_encoder_generic_if #(.n(2))  bus2 ();
  priority_encoder_generic_if #(.n(64)) bus64 ();

  priority_encoder_generic #(.n(6))  dut6  (.clk(clk), .reset_n(reset_n), .bus(bus6.slave));
  priority_encoder_generic #(.n(2))  dut2  (.clk(clk), .reset_n(reset_n), .bus(bus2.slave));
  priority_encoder_generic #(.n(64)) dut64 (.clk(clk), .reset_n(reset_n), .bus(bus64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] w;
    logic       z;
    logic [2:0] y;
    logic [5:0] oh;
  } vec_t;

  // floor(log2(v)) by repeated halving; 0 maps to 0.
  function automatic int flog2(logic [63:0] v);
    int r;
    r = 0;
    while (v > 64'd1) begin
      v = v / 2;
      r++;
    end
    return r;
  endfunction

  task automatic chk(string tag, int nb, logic [63:0] wv,
                     logic z_a, logic [5:0] y_a, logic [63:0] oh_a);
    logic        ze;
    logic [5:0]  ye;
    logic [63:0] ohe;
    ze  = (wv != 64'd0);
    ye  = 6'(flog2(wv));
    ohe = ze ? (64'd1 << ye) : 64'd0;
    tests_run++;
    if (z_a !== ze || y_a !== ye) begin
      tests_failed++;
      $display("FAIL %s n=%0d w=%h: got z=%b y=%0d, want z=%b y=%0d",
               tag, nb, wv, z_a, y_a, ze, ye);
    end
`ifdef PRIO_ENC_ONEHOT_EN
    tests_run++;
    if (oh_a !== ohe) begin
      tests_failed++;
      $display("FAIL %s/onehot n=%0d w=%h: got %h, want %h", tag, nb, wv, oh_a, ohe);
    end
`else
    if (oh_a !== 64'd0 && ohe === 64'd0) begin
      // onehot absent in this build; nothing to compare
    end
`endif
  endtask

  task automatic check_all(string tag, logic [5:0] a, logic [1:0] b, logic [63:0] c);
    logic [63:0] oh6, oh2, oh64;
`ifdef PRIO_ENC_ONEHOT_EN
    oh6 = 64'(bus6.onehot); oh2 = 64'(bus2.onehot); oh64 = bus64.onehot;
`else
    oh6 = 64'd0; oh2 = 64'd0; oh64 = 64'd0;
`endif
    chk(tag, 6,  64'(a), bus6.z,  6'(bus6.y),  oh6);
    chk(tag, 2,  64'(b), bus2.z,  6'(bus2.y),  oh2);
    chk(tag, 64, c,      bus64.z, bus64.y,     oh64);
  endtask

  // Drive on negedge, confirm outputs still show the previous request just
  // before the edge, then confirm the new encoding right after it.
  task automatic step(string tag, logic [5:0] a, logic [1:0] b, logic [63:0] c);
    @(negedge clk);
    bus6.w = a; bus2.w = b; bus64.w = c;
    #1 check_all({tag, "/hold"}, p6, p2, p64);
    @(posedge clk);
    #1 check_all(tag, a, b, c);
    $display("[TB] %s w6=%b w2=%b w64=%h -> y6=%0d y2=%0d y64=%0d",
             tag, a, b, c, bus6.y, bus2.y, bus64.y);
    p6 = a; p2 = b; p64 = c;
  endtask

  function automatic logic [63:0] rand64();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r >> $urandom_range(63, 0);
  endfunction

  vec_t vecs[6];

  initial begin
    tests_run = 0;
    tests_failed = 0;
    vecs[0] = '{w: 6'b000000, z: 1'b0, y: 3'd0, oh: 6'b000000};
    vecs[1] = '{w: 6'b000001, z: 1'b1, y: 3'd0, oh: 6'b000001};
    vecs[2] = '{w: 6'b101100, z: 1'b1, y: 3'd5, oh: 6'b100000};
    vecs[3] = '{w: 6'b011010, z: 1'b1, y: 3'd4, oh: 6'b010000};
    vecs[4] = '{w: 6'b111111, z: 1'b1, y: 3'd5, oh: 6'b100000};
    vecs[5] = '{w: 6'b000110, z: 1'b1, y: 3'd2, oh: 6'b000100};

    // Asynchronous reset before any clock edge.
    reset_n = 1'b1;
    bus6.w = 6'b111111; bus2.w = 2'b11; bus64.w = '1;
    #1 reset_n = 1'b0;
    #1 check_all("async_rst", 6'd0, 2'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1 check_all("rst_hold", 6'd0, 2'd0, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus6.w = 6'd0; bus2.w = 2'd0; bus64.w = 64'd0;
    p6 = 6'd0; p2 = 2'd0; p64 = 64'd0;

    // Table vectors for n=6, with explicit table expectations too.
    foreach (vecs[i]) begin
      step("tbl", vecs[i].w, 2'($urandom_range(3, 0)), rand64());
      tests_run++;
      if (bus6.z !== vecs[i].z || bus6.y !== vecs[i].y) begin
        tests_failed++;
        $display("FAIL tbl_vec%0d: got z=%b y=%0d, want z=%b y=%0d",
                 i, bus6.z, bus6.y, vecs[i].z, vecs[i].y);
      end
`ifdef PRIO_ENC_ONEHOT_EN
      tests_run++;
      if (bus6.onehot !== vecs[i].oh) begin
        tests_failed++;
        $display("FAIL tbl_oh%0d: got %b, want %b", i, bus6.onehot, vecs[i].oh);
      end
`endif
    end

    // n=64 and n=2 boundaries.
    step("b64_ones", 6'd0, 2'b11, '1);
    step("b64_zero", 6'd0, 2'b00, 64'd0);
    step("b64_bit0", 6'd0, 2'b01, 64'd1);
    step("b64_bit63", 6'd0, 2'b10, 64'd1 << 63);

    // Counting sweep with an asynchronous reset pulse at w=100000.
    for (int i = 0; i < 128; i++) begin
      logic [63:0] c;
      c = (64'd1 << (i % 64)) | ({$urandom, $urandom} & ((64'd1 << (i % 64)) - 64'd1));
      step("sweep", 6'(i % 64), 2'(i % 4), c);
      if (i == 32) begin
        #2 reset_n = 1'b0;
        #1 check_all("mid_rst", 6'd0, 2'd0, 64'd0);
        @(posedge clk);
        #1 check_all("mid_rst_hold", 6'd0, 2'd0, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check_all("mid_rst_rel", 6'd0, 2'd0, 64'd0);
        @(posedge clk);
        #1 check_all("post_rst", 6'(i % 64), 2'(i % 4), c);
        tests_run++;
        if (bus6.z !== 1'b1 || bus6.y !== 3'd5) begin
          tests_failed++;
          $display("FAIL post_rst_y5: got z=%b y=%0d, want z=1 y=5", bus6.z, bus6.y);
        end
      end
    end

    // Random stimulus.
    for (int i = 0; i < 200; i++) begin
      step("rand", 6'($urandom_range(63, 0)), 2'($urandom_range(3, 0)), rand64());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end
endmodule
